ex_hazard_scheduler: RTL and testbench

EX_HAZARD_SCHEDULER -- requirements
Module: ex_hazard_scheduler

---
 rtl/ex_hazard_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_ex_hazard_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// ex_hazard_scheduler
//
// Hazard unit for a classic five-stage integer pipeline. It shadows the
// destination fields of the instructions sitting in EX and MEM. Against those
// it:
//   * registers the operand-forwarding selects for the instruction that is
//     about to enter EX,
//   * detects load-use hazards and requests a one-cycle stall plus bubble,
//   * handles EX-stage redirects by squashing IF/ID for two cycles.
//
// Ports
//   clock            : single clock, rising-edge active
//   reset            : synchronous, active-low reset
//   id_*             : fields of the instruction currently in Decode
//   flush_ip         : EX-stage redirect (mispredict or jump) this cycle
//   fa_mux_op        : registered ALU operand A select for the EX instruction
//   fb_mux_op        : registered ALU operand B / store-data select for EX
//   stall_op         : hold PC and IF/ID (combinational)
//   bubble_ex_op     : load a NOP into ID/EX (combinational)
//   flush_if_id_op   : invalidate IF/ID (combinational)
//   stall_cnt_op     : saturating count of stall cycles (registered)
//   flush_cnt_op     : saturating count of accepted redirects (registered)
// ---------------------------------------------------------------------------

package ex_hazard_scheduler_pkg;

    // Forwarding selects seen by the EX-stage operand muxes.
    typedef enum logic [2:0] {
        NO_FORWARD_SELECT  = 3'd0,  // take the value read from the register file
        EX_RESULT_SELECT   = 3'd1,  // ALU result of the instruction now in MEM
        WB_RESULT_SELECT   = 3'd2,  // write-back value of the instruction now in WB
        MEM_DATA_EX_SELECT = 3'd3,  // store data from the instruction now in MEM
        MEM_DATA_WB_SELECT = 3'd4   // store data from the instruction now in WB
    } forward_mux_code;

    typedef enum logic [1:0] {
        ST_RUN           = 2'd0,
        ST_LU_STALL      = 2'd1,
        ST_FLUSH_RECOVER = 2'd2
    } sched_state_t;

    // Destination information tracked for an in-flight instruction.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } pipe_slot_t;

endpackage

module ex_hazard_scheduler
    import ex_hazard_scheduler_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic            id_is_store,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_reg_write,
    input  logic            id_is_load,
    input  logic            flush_ip,
    output forward_mux_code fa_mux_op,
    output forward_mux_code fb_mux_op,
    output logic            stall_op,
    output logic            bubble_ex_op,
    output logic            flush_if_id_op,
    output logic [15:0]     stall_cnt_op,
    output logic [15:0]     flush_cnt_op
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    sched_state_t    state_q;
    sched_state_t    state_d;
    pipe_slot_t      ex_slot_q;
    pipe_slot_t      mem_slot_q;
    forward_mux_code fa_q;
    forward_mux_code fb_q;
    forward_mux_code fa_d;
    forward_mux_code fb_d;
    logic [15:0]     stall_cnt_q;
    logic [15:0]     flush_cnt_q;

    logic rs1_ex_hit;
    logic rs1_mem_hit;
    logic rs2_ex_hit;
    logic rs2_mem_hit;
    logic load_use;
    logic flush_accept;

    // A source depends on a slot only if the slot will really write that
    // register; x0 is hard-wired to zero and never forwarded.
    function automatic logic src_match(input logic       used,
                                       input logic [4:0] rs,
                                       input pipe_slot_t slot);
        return used && (rs != 5'd0) && slot.valid && slot.reg_write &&
               (slot.rd == rs);
    endfunction

    always_comb begin
        rs1_ex_hit  = src_match(id_rs1_used, id_rs1_addr, ex_slot_q);
        rs1_mem_hit = src_match(id_rs1_used, id_rs1_addr, mem_slot_q);
        rs2_ex_hit  = src_match(id_rs2_used, id_rs2_addr, ex_slot_q);
        rs2_mem_hit = src_match(id_rs2_used, id_rs2_addr, mem_slot_q);
        // A load in EX has no data until after MEM, so a dependent instruction
        // in Decode cannot be served by forwarding yet.
        load_use    = id_valid && ex_slot_q.is_load && (rs1_ex_hit || rs2_ex_hit);
    end

    // Next forwarding selects; the EX slot is checked first because it holds
    // the younger, and therefore architecturally current, write.
    always_comb begin
        fa_d = NO_FORWARD_SELECT;
        fb_d = NO_FORWARD_SELECT;

        if (rs1_ex_hit) begin
            fa_d = EX_RESULT_SELECT;
        end else if (rs1_mem_hit) begin
            fa_d = WB_RESULT_SELECT;
        end

        if (id_is_store) begin
            // rs2 of a store is the data to be written, which has its own mux.
            if (rs2_ex_hit) begin
                fb_d = MEM_DATA_EX_SELECT;
            end else if (rs2_mem_hit) begin
                fb_d = MEM_DATA_WB_SELECT;
            end
        end else begin
            if (rs2_ex_hit) begin
                fb_d = EX_RESULT_SELECT;
            end else if (rs2_mem_hit) begin
                fb_d = WB_RESULT_SELECT;
            end
        end
    end

    // Pipeline control decode. Outputs are combinational from the current
    // state so the IF/ID and ID/EX registers react in the same cycle.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        stall_op       = 1'b0;
        bubble_ex_op   = 1'b0;
        flush_if_id_op = 1'b0;
        flush_accept   = 1'b0;
        state_d        = ST_RUN;

        case (state_q)
            ST_RUN, ST_LU_STALL: begin
                if (flush_ip) begin
                    // Redirect wins over load-use: the dependent instruction
                    // is on the wrong path, so stalling for it is pointless.
                    flush_if_id_op = 1'b1;
                    bubble_ex_op   = 1'b1;
                    flush_accept   = 1'b1;
                    state_d        = ST_FLUSH_RECOVER;
                end else if ((state_q == ST_RUN) && load_use) begin
                    stall_op     = 1'b1;
                    bubble_ex_op = 1'b1;
                    state_d      = ST_LU_STALL;
                end
            end
            ST_FLUSH_RECOVER: begin
                // The wrong-path fetch that was in IF during the redirect has
                // now reached IF/ID and must be squashed as well.
                flush_if_id_op = 1'b1;
                bubble_ex_op   = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            // NOTE: only valid bits strictly need clearing, but the slots are
            // tiny so the whole struct is cleared for clean waveforms.
            state_q     <= ST_RUN;
            ex_slot_q   <= '0;
            mem_slot_q  <= '0;
            fa_q        <= NO_FORWARD_SELECT;
            fb_q        <= NO_FORWARD_SELECT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_slot_q <= ex_slot_q;

            if (id_valid && !bubble_ex_op) begin
                ex_slot_q <= '{valid:     1'b1,
                               rd:        id_rd_addr,
                               reg_write: id_reg_write,
                               is_load:   id_is_load};
            end else begin
                ex_slot_q <= '0;
            end

            // A bubble in EX needs no forwarding; while Decode is held
            // without a bubble the EX instruction keeps its selects.
            if (bubble_ex_op) begin
                fa_q <= NO_FORWARD_SELECT;
                fb_q <= NO_FORWARD_SELECT;
            end else if (!stall_op) begin
                fa_q <= fa_d;
                fb_q <= fb_d;
            end

            if (stall_op && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end

            if (flush_accept && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign fa_mux_op    = fa_q;
    assign fb_mux_op    = fb_q;
    assign stall_cnt_op = stall_cnt_q;
    assign flush_cnt_op = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ex_hazard_scheduler
//
// Directed bench for ex_hazard_scheduler. Inputs change just after the
// falling edge; combinational outputs are checked 1 ns later and registered
// outputs one falling edge after the rising edge that loads them.
// ---------------------------------------------------------------------------

module tb_ex_hazard_scheduler;
    import ex_hazard_scheduler_pkg::*;

    logic            clock;
    logic            reset;
    logic            id_valid;
    logic [4:0]      id_rs1_addr;
    logic [4:0]      id_rs2_addr;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic            id_is_store;
    logic [4:0]      id_rd_addr;
    logic            id_reg_write;
    logic            id_is_load;
    logic            flush_ip;
    forward_mux_code fa_mux_op;
    forward_mux_code fb_mux_op;
    logic            stall_op;
    logic            bubble_ex_op;
    logic            flush_if_id_op;
    logic [15:0]     stall_cnt_op;
    logic [15:0]     flush_cnt_op;

    int n_checks = 0;
    int n_fail   = 0;

    ex_hazard_scheduler dut (
        .clock          (clock),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_is_store    (id_is_store),
        .id_rd_addr     (id_rd_addr),
        .id_reg_write   (id_reg_write),
        .id_is_load     (id_is_load),
        .flush_ip       (flush_ip),
        .fa_mux_op      (fa_mux_op),
        .fb_mux_op      (fb_mux_op),
        .stall_op       (stall_op),
        .bubble_ex_op   (bubble_ex_op),
        .flush_if_id_op (flush_if_id_op),
        .stall_cnt_op   (stall_cnt_op),
        .flush_cnt_op   (flush_cnt_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle and park just after the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic st,
                          input logic [4:0] rd, input logic rw, input logic ld);
        id_valid     = v;
        id_rs1_addr  = rs1;
        id_rs1_used  = u1;
        id_rs2_addr  = rs2;
        id_rs2_used  = u2;
        id_is_store  = st;
        id_rd_addr   = rd;
        id_reg_write = rw;
        id_is_load   = ld;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic check_ctrl(input string tag, input logic st,
                              input logic bub, input logic fl);
        check({tag, ".stall"},  {31'd0, stall_op},       {31'd0, st});
        check({tag, ".bubble"}, {31'd0, bubble_ex_op},   {31'd0, bub});
        check({tag, ".flush"},  {31'd0, flush_if_id_op}, {31'd0, fl});
    endtask

    initial begin
        reset    = 1'b0;
        flush_ip = 1'b0;
        idle();

        // ---------------- reset state ----------------
        tick();
        tick();
        #1;
        check("rst.fa", fa_mux_op, NO_FORWARD_SELECT);
        check("rst.fb", fb_mux_op, NO_FORWARD_SELECT);
        check("rst.stall_cnt", stall_cnt_op, 0);
        check("rst.flush_cnt", flush_cnt_op, 0);
        check("rst.state", dut.state_q, ST_RUN);
        check_ctrl("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();

        // ---------------- addi x5 ; add x6,x5,x5 ----------------
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        #1 check_ctrl("alu.addi", 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        #1 check_ctrl("alu.add", 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        check("alu.fa", fa_mux_op, EX_RESULT_SELECT);
        check("alu.fb", fb_mux_op, EX_RESULT_SELECT);
        check("alu.stall_cnt", stall_cnt_op, 0);
        tick();
        tick();

        // ---------------- lw x7 ; add x8,x7,x1 ----------------
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        #1 check_ctrl("lu.hit", 1'b1, 1'b1, 1'b0);
        tick();
        #1;
        check_ctrl("lu.after", 1'b0, 1'b0, 1'b0);
        check("lu.stall_cnt", stall_cnt_op, 1);
        check("lu.fa_bubble", fa_mux_op, NO_FORWARD_SELECT);
        check("lu.state", dut.state_q, ST_LU_STALL);
        tick();
        idle();
        #1;
        check("lu.fa", fa_mux_op, WB_RESULT_SELECT);
        check("lu.fb", fb_mux_op, NO_FORWARD_SELECT);
        check("lu.stall_cnt2", stall_cnt_op, 1);
        tick();
        tick();

        // ---------------- x3 written in EX and MEM ----------------
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        tick();
        #1;
        check("pri.fa", fa_mux_op, EX_RESULT_SELECT);
        check("pri.fb_x0", fb_mux_op, NO_FORWARD_SELECT);
        // EX now holds x10, MEM holds the younger x3 write.
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
        tick();
        idle();
        #1 check("mem.fa", fa_mux_op, WB_RESULT_SELECT);
        tick();
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
        tick();
        idle();
        #1 check("x0.fa", fa_mux_op, NO_FORWARD_SELECT);
        tick();
        tick();

        // ---------------- stores ----------------
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        check("sw.fb", fb_mux_op, MEM_DATA_EX_SELECT);
        check("sw.fa", fa_mux_op, NO_FORWARD_SELECT);
        tick();
        tick();
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 check_ctrl("lwsw.hit", 1'b1, 1'b1, 1'b0);
        tick();
        #1 check_ctrl("lwsw.after", 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        check("lwsw.fb", fb_mux_op, MEM_DATA_WB_SELECT);
        check("lwsw.stall_cnt", stall_cnt_op, 2);
        tick();
        tick();

        // ---------------- invalid Decode never stalls ----------------
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        #1 check_ctrl("inv", 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();

        // ---------------- flush coincident with load-use ----------------
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        flush_ip = 1'b1;
        #1 check_ctrl("fl.c1", 1'b0, 1'b1, 1'b1);
        tick();
        // flush_ip kept high: must be ignored in FLUSH_RECOVER.
        #1;
        check_ctrl("fl.c2", 1'b0, 1'b1, 1'b1);
        check("fl.cnt1", flush_cnt_op, 1);
        check("fl.state", dut.state_q, ST_FLUSH_RECOVER);
        tick();
        flush_ip = 1'b0;
        idle();
        #1;
        check_ctrl("fl.c3", 1'b0, 1'b0, 1'b0);
        check("fl.cnt2", flush_cnt_op, 1);
        check("fl.stall_cnt", stall_cnt_op, 2);
        tick();

        // ---------------- flush counter saturation ----------------
        force dut.flush_cnt_q = 16'hFFFE;
        #1 release dut.flush_cnt_q;
        #1 check("sat.preset", flush_cnt_op, 16'hFFFE);
        flush_ip = 1'b1;
        tick();
        flush_ip = 1'b0;
        #1 check("sat.ffff", flush_cnt_op, 16'hFFFF);
        tick();
        flush_ip = 1'b1;
        tick();
        flush_ip = 1'b0;
        #1 check("sat.hold", flush_cnt_op, 16'hFFFF);
        tick();

        // ---------------- stall counter saturation ----------------
        force dut.stall_cnt_q = 16'hFFFF;
        #1 release dut.stall_cnt_q;
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
        #1 check_ctrl("ssat.hit", 1'b1, 1'b1, 1'b0);
        tick();
        #1;
        check("ssat.hold", stall_cnt_op, 16'hFFFF);

        // ---------------- reset while in LU_STALL ----------------
        // Still in LU_STALL here; keep the dependent add in Decode.
        check("rlu.state", dut.state_q, ST_LU_STALL);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rlu.state_run", dut.state_q, ST_RUN);
        check_ctrl("rlu", 1'b0, 1'b0, 1'b0);
        check("rlu.stall_cnt", stall_cnt_op, 0);
        check("rlu.flush_cnt", flush_cnt_op, 0);
        check("rlu.fa", fa_mux_op, NO_FORWARD_SELECT);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
